// File: rtl/cmd_arbiter.sv
// Shares the SD CMD-line engine between the software (req 0) and auto-command (req 1) paths.
// It grants requests round-robin, issues them to the engine and returns one result per grant.
module cmd_arbiter #(
    parameter int WATCHDOG_CYCLES = 1024,
    parameter bit AUTO_FIRST      = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [1:0][5:0]  req_cmd_i,
    input  logic [1:0][31:0] req_arg_i,
    input  logic [1:0][1:0]  req_rsp_type_i,
    input  logic             abort_i,
    output logic [5:0]       cmd_o,
    output logic [31:0]      cmd_arg_o,
    output logic [1:0]       response_type_o,
    output logic             cmd_valid_o,
    input  logic             cmd_ready_i,
    input  logic             cmd_done_i,
    input  logic             cmd_result_valid_i,
    input  logic             timeout_error_i,
    input  logic             index_error_i,
    input  logic             end_bit_error_i,
    input  logic             crc_error_i,
    input  logic [119:0]     rsp_i,
    output logic             res_valid_o,
    output logic             res_id_o,
    output logic [119:0]     res_rsp_o,
    output logic [4:0]       res_err_o,
    output logic             busy_o
);
    localparam int WD_W = $clog2(WATCHDOG_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 2);
    localparam logic [WD_W-1:0] WD_MAX  = '1;
    localparam logic [1:0] NO_RESPONSE  = 2'b00;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_CMD, WAIT_RSP, REPORT} state_t;

    state_t          state_reg, state_next;
    logic            last_reg, last_next;
    logic            id_reg, id_next;
    logic [5:0]      cmd_reg, cmd_next;
    logic [31:0]     arg_reg, arg_next;
    logic [1:0]      type_reg, type_next;
    logic [WD_W-1:0] wd_reg, wd_next;
    logic            res_valid_reg, res_valid_next;
    logic            res_id_reg, res_id_next;
    logic [119:0]    res_rsp_reg, res_rsp_next;
    logic [4:0]      res_err_reg, res_err_next;

    logic            grant_valid;
    logic            grant_id;
    logic            wd_fire;
    logic            finish;
    logic [119:0]    fin_rsp;
    logic [4:0]      fin_err;

    // On a tie the requester not granted last wins; a lone request always wins.
    assign grant_id    = (&req_valid_i) ? ~last_reg : req_valid_i[1];
    assign grant_valid = (state_reg == IDLE) && !abort_i && (|req_valid_i);
    // wd_reg+1 waiting cycles have elapsed; forcing at the (N-1)th lands the result N cycles after handshake.
    assign wd_fire     = (wd_reg == WD_LAST);

    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        assign req_ready_o[gi] = grant_valid && (grant_id == 1'(gi));
    end

    always_comb begin
        state_next     = state_reg;
        last_next      = last_reg;
        id_next        = id_reg;
        cmd_next       = cmd_reg;
        arg_next       = arg_reg;
        type_next      = type_reg;
        wd_next        = wd_reg;
        res_valid_next = 1'b0;
        res_id_next    = res_id_reg;
        res_rsp_next   = res_rsp_reg;
        res_err_next   = res_err_reg;
        finish         = 1'b0;
        fin_rsp        = '0;
        fin_err        = '0;

        if (abort_i) begin
            state_next = IDLE;
            wd_next    = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        state_next = ISSUE;
                        last_next  = grant_id;
                        id_next    = grant_id;
                        cmd_next   = req_cmd_i[grant_id];
                        arg_next   = req_arg_i[grant_id];
                        type_next  = req_rsp_type_i[grant_id];
                    end
                end
                ISSUE: begin
                    if (cmd_ready_i) begin
                        wd_next    = '0;
                        state_next = (type_reg == NO_RESPONSE) ? WAIT_CMD : WAIT_RSP;
                    end
                end
                WAIT_CMD: begin
                    if (cmd_done_i) begin
                        finish = 1'b1;
                    end else if (wd_fire) begin
                        finish  = 1'b1;
                        fin_err = 5'b10000;
                    end
                end
                WAIT_RSP: begin
                    if (cmd_result_valid_i) begin
                        finish  = 1'b1;
                        fin_rsp = rsp_i;
                        fin_err = {2'b00, index_error_i, end_bit_error_i, crc_error_i};
                    end else if (timeout_error_i) begin
                        finish  = 1'b1;
                        fin_err = 5'b01000;
                    end else if (wd_fire) begin
                        finish  = 1'b1;
                        fin_err = 5'b10000;
                    end
                end
                REPORT:  state_next = IDLE;
                default: state_next = IDLE;
            endcase

            if ((state_reg == WAIT_CMD || state_reg == WAIT_RSP) && wd_reg != WD_MAX) begin
                wd_next = wd_reg + 1'b1;
            end
            if (finish) begin
                state_next     = REPORT;
                res_valid_next = 1'b1;
                res_id_next    = id_reg;
                res_rsp_next   = fin_rsp;
                res_err_next   = fin_err;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg     <= IDLE;
            last_reg      <= ~AUTO_FIRST;
            id_reg        <= 1'b0;
            cmd_reg       <= '0;
            arg_reg       <= '0;
            type_reg      <= '0;
            wd_reg        <= '0;
            res_valid_reg <= 1'b0;
            res_id_reg    <= 1'b0;
            res_rsp_reg   <= '0;
            res_err_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            last_reg      <= last_next;
            id_reg        <= id_next;
            cmd_reg       <= cmd_next;
            arg_reg       <= arg_next;
            type_reg      <= type_next;
            wd_reg        <= wd_next;
            res_valid_reg <= res_valid_next;
            res_id_reg    <= res_id_next;
            res_rsp_reg   <= res_rsp_next;
            res_err_reg   <= res_err_next;
        end
    end

    assign cmd_o           = cmd_reg;
    assign cmd_arg_o       = arg_reg;
    assign response_type_o = type_reg;
    assign cmd_valid_o     = (state_reg == ISSUE);
    assign busy_o          = (state_reg != IDLE);
    assign res_valid_o     = res_valid_reg;
    assign res_id_o        = res_id_reg;
    assign res_rsp_o       = res_rsp_reg;
    assign res_err_o       = res_err_reg;
endmodule

// File: tb/tb_cmd_arbiter.sv
// Bench for cmd_arbiter: directed scenarios with literal expectations plus random traffic,
// all checked every cycle against a transaction-level model of the arbiter.
module tb_cmd_arbiter;
    localparam int WD = 16;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_ready;
    logic [1:0][5:0]  req_cmd = '0;
    logic [1:0][31:0] req_arg = '0;
    logic [1:0][1:0]  req_type = '0;
    logic             abort = 1'b0;
    logic [5:0]       cmd;
    logic [31:0]      cmd_arg;
    logic [1:0]       response_type;
    logic             cmd_valid;
    logic             cmd_ready = 1'b0;
    logic             cmd_done = 1'b0;
    logic             result_valid = 1'b0;
    logic             timeout = 1'b0;
    logic             index_err = 1'b0;
    logic             end_bit_err = 1'b0;
    logic             crc_err = 1'b0;
    logic [119:0]     rsp = '0;
    logic             res_valid;
    logic             res_id;
    logic [119:0]     res_rsp;
    logic [4:0]       res_err;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    cmd_arbiter #(.WATCHDOG_CYCLES(WD), .AUTO_FIRST(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_cmd_i(req_cmd), .req_arg_i(req_arg), .req_rsp_type_i(req_type),
        .abort_i(abort),
        .cmd_o(cmd), .cmd_arg_o(cmd_arg), .response_type_o(response_type),
        .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready),
        .cmd_done_i(cmd_done), .cmd_result_valid_i(result_valid),
        .timeout_error_i(timeout), .index_error_i(index_err),
        .end_bit_error_i(end_bit_err), .crc_error_i(crc_err), .rsp_i(rsp),
        .res_valid_o(res_valid), .res_id_o(res_id), .res_rsp_o(res_rsp),
        .res_err_o(res_err), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Transaction-level model: one outstanding command, who wins the next tie, and the last result.
    bit           m_on = 1'b0;
    bit           m_have = 1'b0;
    bit           m_acc = 1'b0;
    bit           m_report = 1'b0;
    bit           m_tie = 1'b1;
    bit           m_id = 1'b0;
    logic [5:0]   m_cmd = '0;
    logic [31:0]  m_arg = '0;
    logic [1:0]   m_type = '0;
    int           m_hs = 0;
    bit           m_res_id = 1'b0;
    logic [119:0] m_res_rsp = '0;
    logic [4:0]   m_res_err = '0;

    always @(negedge clk) begin : compare
        logic         g_valid;
        logic         g_id;
        logic [1:0]   exp_ready;
        logic         fin;
        logic [119:0] f_rsp;
        logic [4:0]   f_err;
        g_valid   = !m_have && !m_report && !abort && (req_valid != 2'b00);
        g_id      = (req_valid == 2'b11) ? m_tie : req_valid[1];
        exp_ready = g_valid ? (g_id ? 2'b10 : 2'b01) : 2'b00;
        if (m_on) begin
            chk("req_ready", 128'(req_ready), 128'(exp_ready));
            chk("cmd_valid", 128'(cmd_valid), 128'(m_have && !m_acc));
            if (m_have && !m_acc) begin
                chk("cmd", 128'(cmd), 128'(m_cmd));
                chk("cmd_arg", 128'(cmd_arg), 128'(m_arg));
                chk("rsp_type", 128'(response_type), 128'(m_type));
            end
            chk("busy", 128'(busy), 128'(m_have || m_report));
            chk("res_valid", 128'(res_valid), 128'(m_report));
            chk("res_id", 128'(res_id), 128'(m_res_id));
            chk("res_rsp", 128'(res_rsp), 128'(m_res_rsp));
            chk("res_err", 128'(res_err), 128'(m_res_err));
        end
        if (!rst_ni) begin
            m_on <= 1'b1; m_have <= 1'b0; m_acc <= 1'b0; m_report <= 1'b0; m_tie <= 1'b1;
            m_id <= 1'b0; m_cmd <= '0; m_arg <= '0; m_type <= '0;
            m_res_id <= 1'b0; m_res_rsp <= '0; m_res_err <= '0;
        end else begin
            m_report <= 1'b0;
            if (abort) begin
                m_have <= 1'b0;
            end else if (m_report) begin
                m_have <= 1'b0;
            end else if (g_valid) begin
                m_have <= 1'b1; m_acc <= 1'b0; m_id <= g_id; m_tie <= ~g_id;
                m_cmd <= req_cmd[g_id]; m_arg <= req_arg[g_id]; m_type <= req_type[g_id];
            end else if (m_have && !m_acc) begin
                if (cmd_ready) begin
                    m_acc <= 1'b1;
                    m_hs  <= cyc;
                end
            end else if (m_have) begin
                fin = 1'b0; f_rsp = '0; f_err = '0;
                if (m_type == 2'b00) begin
                    fin = cmd_done;
                end else if (result_valid) begin
                    fin = 1'b1; f_rsp = rsp; f_err = {2'b00, index_err, end_bit_err, crc_err};
                end else if (timeout) begin
                    fin = 1'b1; f_err = 5'b01000;
                end
                // Forced completion WD-1 cycles after the handshake gives a result WD cycles after it.
                if (!fin && (cyc - m_hs == WD - 1)) begin
                    fin = 1'b1; f_err = 5'b10000;
                end
                if (fin) begin
                    m_have <= 1'b0; m_report <= 1'b1;
                    m_res_id <= m_id; m_res_rsp <= f_rsp; m_res_err <= f_err;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_pulses();
        cmd_done = 1'b0; result_valid = 1'b0; timeout = 1'b0; abort = 1'b0;
        index_err = 1'b0; end_bit_err = 1'b0; crc_err = 1'b0; rsp = '0;
    endtask

    task automatic do_reset();
        tick();
        rst_ni = 1'b0; req_valid = '0; cmd_ready = 1'b0;
        clear_pulses();
        tick();
        sample();
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_cmd_valid", 128'(cmd_valid), 128'(0));
        chk("rst_res_valid", 128'(res_valid), 128'(0));
        chk("rst_outputs", 128'({cmd, cmd_arg, response_type, res_err}), 128'(0));
        tick();
        rst_ni = 1'b1;
    endtask

    // Grant cycle, then `stall` ISSUE cycles with cmd_ready low, then the handshake cycle.
    task automatic grant_issue(input logic [1:0] mask, input logic id, input logic [5:0] c,
                               input logic [31:0] a, input logic [1:0] t,
                               input logic [1:0] exp_ready, input int stall,
                               input logic [1:0] keep, input string tag);
        tick();
        req_valid = mask; req_cmd[id] = c; req_arg[id] = a; req_type[id] = t; cmd_ready = 1'b0;
        sample();
        chk({tag, "_grant"}, 128'(req_ready), 128'(exp_ready));
        for (int k = 0; k <= stall; k++) begin
            tick();
            req_valid = keep;
            cmd_ready = (k == stall);
            sample();
            chk({tag, "_issue"}, 128'({cmd_valid, cmd}), 128'({1'b1, c}));
            chk({tag, "_no_regrant"}, 128'(req_ready), 128'(0));
        end
    endtask

    // Engine pulse this cycle; result must appear exactly one cycle later.
    task automatic pulse_and_check(input logic dn, input logic rv, input logic to,
                                   input logic [2:0] flags, input logic [119:0] r,
                                   input logic exp_id, input logic [4:0] exp_err,
                                   input logic [119:0] exp_rsp, input string tag);
        tick();
        cmd_done = dn; result_valid = rv; timeout = to;
        {index_err, end_bit_err, crc_err} = flags; rsp = r;
        sample();
        chk({tag, "_no_early"}, 128'(res_valid), 128'(0));
        tick();
        clear_pulses();
        sample();
        chk({tag, "_res_valid"}, 128'(res_valid), 128'(1));
        chk({tag, "_res_id"}, 128'(res_id), 128'(exp_id));
        chk({tag, "_res_err"}, 128'(res_err), 128'(exp_err));
        chk({tag, "_res_rsp"}, 128'(res_rsp), 128'(exp_rsp));
    endtask

    initial begin
        logic [127:0] r128;
        bit quiet;
        bit early;

        // 1: sw CMD0 with no response; done at cycle 12, result at cycle 13.
        do_reset();
        tick();
        req_valid = 2'b01; req_cmd[0] = 6'd0; req_arg[0] = '0; req_type[0] = 2'b00; cmd_ready = 1'b1;
        sample();
        chk("t1_grant", 128'(req_ready), 128'(2'b01));
        tick();
        req_valid = 2'b00;
        sample();
        chk("t1_cmd_valid", 128'(cmd_valid), 128'(1));
        repeat (10) tick();
        pulse_and_check(1'b1, 1'b0, 1'b0, 3'b000, '0, 1'b0, 5'b00000, '0, "t1");
        $display("t1 sw CMD0 done -> id=%0d err=%b", res_id, res_err);
        tick();
        sample();
        chk("t1_one_cycle", 128'({res_valid, busy}), 128'(0));

        // 2: both valid after reset: auto first, then sw, then auto again.
        do_reset();
        req_cmd[0] = 6'd13; req_type[0] = 2'b00;
        grant_issue(2'b11, 1'b1, 6'd12, 32'h0, 2'b00, 2'b10, 0, 2'b11, "t2a");
        pulse_and_check(1'b1, 1'b0, 1'b0, 3'b000, '0, 1'b1, 5'b00000, '0, "t2a");
        grant_issue(2'b11, 1'b0, 6'd13, 32'h1234, 2'b00, 2'b01, 0, 2'b11, "t2b");
        pulse_and_check(1'b1, 1'b0, 1'b0, 3'b000, '0, 1'b0, 5'b00000, '0, "t2b");
        grant_issue(2'b11, 1'b1, 6'd12, 32'h0, 2'b00, 2'b10, 0, 2'b00, "t2c");
        pulse_and_check(1'b1, 1'b0, 1'b0, 3'b000, '0, 1'b1, 5'b00000, '0, "t2c");
        $display("t2 round robin auto,sw,auto done");

        // 3: R1 with CRC error, held two cycles before the engine accepts.
        grant_issue(2'b01, 1'b0, 6'd17, 32'hDEAD_BEEF, 2'b01, 2'b01, 2, 2'b00, "t3");
        pulse_and_check(1'b0, 1'b1, 1'b0, 3'b001, 120'hABCD, 1'b0, 5'b00001, 120'hABCD, "t3");
        $display("t3 crc error -> err=%b rsp=%0h", res_err, res_rsp);

        // 4: result and timeout together: result wins.
        grant_issue(2'b01, 1'b0, 6'd2, 32'h0, 2'b10, 2'b01, 0, 2'b00, "t4");
        pulse_and_check(1'b0, 1'b1, 1'b1, 3'b000, 120'h1234_5678_9ABC, 1'b0, 5'b00000,
                        120'h1234_5678_9ABC, "t4");
        $display("t4 result beats timeout -> err=%b", res_err);

        // 5: silent engine: watchdog result exactly WD cycles after the handshake.
        grant_issue(2'b10, 1'b1, 6'd23, 32'h8, 2'b01, 2'b10, 0, 2'b00, "t5");
        early = 1'b0;
        for (int k = 1; k < WD; k++) begin
            tick();
            sample();
            if (res_valid) early = 1'b1;
        end
        chk("t5_no_early", 128'(early), 128'(0));
        tick();
        sample();
        chk("t5_res", 128'({res_valid, res_id, res_err}), 128'({1'b1, 1'b1, 5'b10000}));
        chk("t5_rsp", 128'(res_rsp), 128'(0));
        $display("t5 watchdog -> err=%b", res_err);

        // 6: abort in WAIT_RSP; pending auto request granted once abort drops.
        grant_issue(2'b01, 1'b0, 6'd9, 32'h0, 2'b01, 2'b01, 0, 2'b00, "t6");
        tick();
        sample();
        chk("t6_waiting", 128'(busy), 128'(1));
        tick();
        abort = 1'b1; req_valid = 2'b10; req_type[1] = 2'b00;
        sample();
        chk("t6_no_grant_abort", 128'(req_ready), 128'(0));
        tick();
        abort = 1'b0;
        sample();
        chk("t6_idle", 128'({busy, res_valid}), 128'(0));
        chk("t6_grant_after", 128'(req_ready), 128'(2'b10));
        tick();
        req_valid = 2'b00; cmd_ready = 1'b1;
        $display("t6 abort -> idle, pending auto granted");

        // Random traffic with periodic silent-engine windows to reach the watchdog.
        for (int i = 0; i < 4000; i++) begin
            tick();
            quiet = ((i / 50) % 4 == 3);
            req_valid = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            for (int j = 0; j < 2; j++) begin
                req_cmd[j]  = 6'($urandom);
                req_arg[j]  = $urandom;
                req_type[j] = 2'($urandom_range(0, 3));
            end
            cmd_ready    = ($urandom_range(0, 1) == 1);
            abort        = ($urandom_range(0, 99) == 0);
            cmd_done     = !quiet && ($urandom_range(0, 5) == 0);
            result_valid = !quiet && ($urandom_range(0, 5) == 0);
            timeout      = !quiet && ($urandom_range(0, 7) == 0);
            index_err    = ($urandom_range(0, 3) == 0);
            end_bit_err  = ($urandom_range(0, 3) == 0);
            crc_err      = ($urandom_range(0, 3) == 0);
            r128 = {$urandom, $urandom, $urandom, $urandom};
            rsp = r128[119:0];
            sample();
            if (res_valid) $display("rand cycle %0d result id=%0d err=%b", cyc, res_id, res_err);
        end
        tick();
        req_valid = '0; cmd_ready = 1'b0;
        clear_pulses();
        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
